atm_controller_param: RTL
=========================

Name: atm_controller_param

Overview:
- Parametrised next-generation ATM session controller.
- Holds an internal account table (PIN, balance, lock flag, failed-try count per account), provisioned through a side port.
- Runs a full session: card insert -> PIN check with lockout -> repeated balance/withdraw/deposit/PIN-change transactions -> eject.
- Sits between the card/keypad front end and the cash dispenser; reports status codes for the display.

Parameters:
ACCT_W, 5, account number width
PIN_W, 4, PIN width
BAL_W, 8, balance width (unsigned)
AMT_W, 8, transaction amount width (AMT_W <= BAL_W)
NUM_ACCTS, 4, table depth (<= 2**ACCT_W); valid accounts are 0..NUM_ACCTS-1
MAX_TRIES, 3, consecutive wrong PINs before lock
TIMEOUT, 16, idle cycles allowed in WAIT_PIN/MENU before forced eject

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
card_in  in  1  level, card present
account  in  ACCT_W  account number, sampled on card_in rising edge in IDLE
pin  in  PIN_W  entered PIN (new PIN for op 11)
pin_valid  in  1  single-cycle strobe, PIN entry
op  in  2  00 balance, 01 withdraw, 10 deposit, 11 PIN change
amount  in  AMT_W  transaction amount
op_valid  in  1  single-cycle strobe, transaction request
cancel  in  1  abort session
prov_we  in  1  provisioning write strobe
prov_idx  in  ACCT_W  provisioning account index
prov_pin  in  PIN_W  provisioned PIN
prov_bal  in  BAL_W  provisioned balance
state  out  3  IDLE=0 WAIT_PIN=1 CHECK_PIN=2 MENU=3 EXEC=4
status  out  3  0 OK, 1 BAD_PIN, 2 LOCKED, 3 INSUFFICIENT, 4 OVERFLOW, 5 TIMEOUT, 6 BAD_ACCT
status_valid  out  1  one-cycle pulse qualifying status
balance  out  BAL_W  balance of the active account after the last op
dispense  out  1  one-cycle pulse on successful withdraw
dispense_amt  out  AMT_W  amount, valid with dispense
eject  out  1  one-cycle pulse when the session ends

Behaviour:
- Reset: state=IDLE; all outputs 0; every table entry pin=0, bal=0, tries=0, locked=0; timeout counter=0.
- IDLE:
  - On card_in rising edge, latch account.
  - If account >= NUM_ACCTS: status=BAD_ACCT pulse + eject; stay in IDLE.
  - If the entry is locked: status=LOCKED + eject.
  - Otherwise go to WAIT_PIN.
- WAIT_PIN, pin_valid at edge k: go to CHECK_PIN. At edge k+1 the result is registered, with status_valid high for the cycle after k+1.
  - Match: tries=0, status=OK, balance=entry bal, go to MENU.
  - Mismatch with tries+1 < MAX_TRIES: tries++, status=BAD_PIN, back to WAIT_PIN.
  - Mismatch with tries+1 = MAX_TRIES: locked=1, tries=0, status=LOCKED, eject, go to IDLE.
- MENU, op_valid at edge k: go to EXEC. At edge k+1 commit, status_valid pulse, return to MENU. Multiple transactions are allowed per session.
  - 00: status=OK, balance=bal.
  - 01: amount > bal gives INSUFFICIENT with no change. Otherwise bal-=amount, dispense pulse, dispense_amt=amount, OK.
  - 10: bal+amount computed at BAL_W+1 bits. If > 2**BAL_W-1, OVERFLOW with no change. Otherwise bal+=amount, OK.
  - 11: entry pin = pin input, OK.
  - amount=0 is legal for 01/10 (OK, dispense still pulses with amt 0).
- Timeout:
  - Counter increments each cycle in WAIT_PIN/MENU with no strobe.
  - It clears on any strobe or on a state change.
  - Reaching TIMEOUT: status=TIMEOUT, eject, go to IDLE. Failed-try count is retained.
- cancel or card_in low in any non-IDLE state: eject pulse, go to IDLE next edge, no status pulse.
  - An EXEC commit in the same cycle is discarded (no balance change, no dispense).
  - cancel takes priority over all strobes.
- pin_valid/op_valid in any state other than WAIT_PIN/MENU respectively: ignored.
- prov_we:
  - Accepted only in IDLE with prov_idx < NUM_ACCTS.
  - Writes pin and bal; clears tries and locked.
  - Ignored otherwise.
  - If it coincides with a card insert on the same index, the provision lands first.
- Async rst mid-session: immediate return to reset values, including the table.

Test Plan:
- Provision idx 2 pin=4'hA bal=100. Insert acct 2, pin A -> status OK, state MENU, balance=100. Withdraw 30 -> dispense pulse with amt 30, balance=70.
- Same session: withdraw 71 -> INSUFFICIENT, balance stays 70, no dispense. Deposit 186 -> OVERFLOW (256). Deposit 185 -> OK, balance=255.
- Acct 1 pin=5: enter 0, 1, 2 -> BAD_PIN, BAD_PIN, then LOCKED + eject. Reinsert -> immediate LOCKED + eject. Reprovision -> login succeeds.
- Insert account 5'd9 -> BAD_ACCT + eject, state stays IDLE.
- Login, then no strobes for 16 cycles -> TIMEOUT, eject, IDLE. Login, op_valid withdraw 10 with cancel on the EXEC cycle -> balance unchanged, no dispense, eject.
- PIN change to 4'h3, remove card, reinsert: old PIN -> BAD_PIN, 4'h3 -> OK. Assert rst mid-MENU -> all outputs 0, state IDLE at once.

Source files
------------

// File: rtl/atm_controller_param.sv
// atm_controller_param: ATM session controller with an internal account table.
// Ports: card_in/account start a session; pin/pin_valid check or change a PIN;
// op/amount/op_valid request balance, withdraw, deposit or PIN change; cancel
// aborts; prov_* provision the table in IDLE. Outputs state, status with its
// status_valid pulse, balance, dispense/dispense_amt and eject pulses.
module atm_controller_param #(
  parameter int ACCT_W    = 5,
  parameter int PIN_W     = 4,
  parameter int BAL_W     = 8,
  parameter int AMT_W     = 8,
  parameter int NUM_ACCTS = 4,
  parameter int MAX_TRIES = 3,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              card_in,
  input  logic [ACCT_W-1:0] account,
  input  logic [PIN_W-1:0]  pin,
  input  logic              pin_valid,
  input  logic [1:0]        op,
  input  logic [AMT_W-1:0]  amount,
  input  logic              op_valid,
  input  logic              cancel,
  input  logic              prov_we,
  input  logic [ACCT_W-1:0] prov_idx,
  input  logic [PIN_W-1:0]  prov_pin,
  input  logic [BAL_W-1:0]  prov_bal,
  output logic [2:0]        state,
  output logic [2:0]        status,
  output logic              status_valid,
  output logic [BAL_W-1:0]  balance,
  output logic              dispense,
  output logic [AMT_W-1:0]  dispense_amt,
  output logic              eject
);
  localparam int IW = NUM_ACCTS > 1 ? $clog2(NUM_ACCTS) : 1;
  localparam int TW = $clog2(MAX_TRIES + 1);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_CHECK = 3'd2, S_MENU = 3'd3, S_EXEC = 3'd4;
  localparam logic [2:0] ST_OK = 3'd0, ST_BAD_PIN = 3'd1, ST_LOCKED = 3'd2, ST_INSUF = 3'd3,
                         ST_OVF = 3'd4, ST_TIMEOUT = 3'd5, ST_BAD_ACCT = 3'd6;

  logic [2:0]        state_q, state_d, status_q, status_d;
  logic              status_valid_q, status_valid_d, dispense_q, dispense_d, eject_q, eject_d;
  logic              card_prev_q;
  logic [BAL_W-1:0]  balance_q, balance_d;
  logic [AMT_W-1:0]  dispense_amt_q, dispense_amt_d, amt_q, amt_d;
  logic [1:0]        op_q, op_d;
  logic [PIN_W-1:0]  pin_q, pin_d;
  logic [IW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [PIN_W-1:0]  pin_tab_q [NUM_ACCTS];
  logic [PIN_W-1:0]  pin_tab_d [NUM_ACCTS];
  logic [BAL_W-1:0]  bal_tab_q [NUM_ACCTS];
  logic [BAL_W-1:0]  bal_tab_d [NUM_ACCTS];
  logic [TW-1:0]     tries_q [NUM_ACCTS];
  logic [TW-1:0]     tries_d [NUM_ACCTS];
  logic              lock_q [NUM_ACCTS];
  logic              lock_d [NUM_ACCTS];

  logic              abort, strobe, insert, acct_ok, prov_ok, to_hit;
  logic [IW-1:0]     ins_idx;
  logic [BAL_W-1:0]  cur_bal;
  logic [BAL_W:0]    sum;
  logic [TW-1:0]     tries_inc;
  logic [CW-1:0]     cnt_inc;

  assign strobe    = pin_valid | op_valid;
  assign insert    = card_in & ~card_prev_q;
  assign abort     = (state_q != S_IDLE) & (cancel | ~card_in);
  assign acct_ok   = {1'b0, account} < (ACCT_W+1)'(NUM_ACCTS);
  assign prov_ok   = {1'b0, prov_idx} < (ACCT_W+1)'(NUM_ACCTS);
  assign ins_idx   = account[IW-1:0];
  assign cur_bal   = bal_tab_q[acc_q];
  assign sum       = {1'b0, cur_bal} + (BAL_W+1)'(amt_q);
  assign tries_inc = tries_q[acc_q] + TW'(1);
  assign cnt_inc   = cnt_q + CW'(1);
  assign to_hit    = ~strobe & (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    status_d       = status_q;
    status_valid_d = 1'b0;
    dispense_d     = 1'b0;
    eject_d        = 1'b0;
    balance_d      = balance_q;
    dispense_amt_d = dispense_amt_q;
    amt_d          = amt_q;
    op_d           = op_q;
    pin_d          = pin_q;
    acc_d          = acc_q;
    pin_tab_d      = pin_tab_q;
    bal_tab_d      = bal_tab_q;
    tries_d        = tries_q;
    lock_d         = lock_q;
    // Provisioning updates the _d copy first so a same-cycle insert sees it.
    if (prov_we && prov_ok && state_q == S_IDLE) begin
      pin_tab_d[prov_idx[IW-1:0]] = prov_pin;
      bal_tab_d[prov_idx[IW-1:0]] = prov_bal;
      tries_d[prov_idx[IW-1:0]]   = '0;
      lock_d[prov_idx[IW-1:0]]    = 1'b0;
    end
    case (state_q)
      S_IDLE: if (insert) begin
        acc_d = ins_idx;
        if (!acct_ok) begin
          status_d = ST_BAD_ACCT; status_valid_d = 1'b1; eject_d = 1'b1;
        end else if (lock_d[ins_idx]) begin
          status_d = ST_LOCKED; status_valid_d = 1'b1; eject_d = 1'b1;
        end else state_d = S_WAIT;
      end
      S_WAIT:
        if (abort) begin
          eject_d = 1'b1; state_d = S_IDLE;
        end else if (pin_valid) begin
          pin_d = pin; state_d = S_CHECK;
        end else if (to_hit) begin
          status_d = ST_TIMEOUT; status_valid_d = 1'b1; eject_d = 1'b1; state_d = S_IDLE;
        end
      S_CHECK: begin
        if (abort) begin
          eject_d = 1'b1; state_d = S_IDLE;
        end else begin
          status_valid_d = 1'b1;
          if (pin_q == pin_tab_q[acc_q]) begin
            tries_d[acc_q] = '0; status_d = ST_OK; balance_d = cur_bal; state_d = S_MENU;
          end else if (tries_inc == TW'(MAX_TRIES)) begin
            lock_d[acc_q] = 1'b1; tries_d[acc_q] = '0; status_d = ST_LOCKED;
            eject_d = 1'b1; state_d = S_IDLE;
          end else begin
            tries_d[acc_q] = tries_inc; status_d = ST_BAD_PIN; state_d = S_WAIT;
          end
        end
      end
      S_MENU:
        if (abort) begin
          eject_d = 1'b1; state_d = S_IDLE;
        end else if (op_valid) begin
          op_d = op; amt_d = amount; pin_d = pin; state_d = S_EXEC;
        end else if (to_hit) begin
          status_d = ST_TIMEOUT; status_valid_d = 1'b1; eject_d = 1'b1; state_d = S_IDLE;
        end
      S_EXEC: begin
        state_d = abort ? S_IDLE : S_MENU;
        eject_d = abort;
        if (!abort) begin
          status_valid_d = 1'b1;
          status_d       = ST_OK;
          balance_d      = cur_bal;
          if (op_q == 2'b01) begin
            if (BAL_W'(amt_q) > cur_bal) status_d = ST_INSUF;
            else begin
              bal_tab_d[acc_q] = cur_bal - BAL_W'(amt_q);
              balance_d        = cur_bal - BAL_W'(amt_q);
              dispense_d       = 1'b1;
              dispense_amt_d   = amt_q;
            end
          end else if (op_q == 2'b10) begin
            if (sum[BAL_W]) status_d = ST_OVF;
            else begin
              bal_tab_d[acc_q] = sum[BAL_W-1:0];
              balance_d        = sum[BAL_W-1:0];
            end
          end else if (op_q == 2'b11) pin_tab_d[acc_q] = pin_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Idle counter runs only while parked in WAIT_PIN/MENU with no strobe.
    cnt_d = ((state_q == S_WAIT || state_q == S_MENU) && state_d == state_q && !strobe) ? cnt_inc : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      status_q       <= '0;
      status_valid_q <= 1'b0;
      dispense_q     <= 1'b0;
      eject_q        <= 1'b0;
      card_prev_q    <= 1'b0;
      balance_q      <= '0;
      dispense_amt_q <= '0;
      amt_q          <= '0;
      op_q           <= '0;
      pin_q          <= '0;
      acc_q          <= '0;
      cnt_q          <= '0;
      for (int i = 0; i < NUM_ACCTS; i++) begin
        pin_tab_q[i] <= '0;
        bal_tab_q[i] <= '0;
        tries_q[i]   <= '0;
        lock_q[i]    <= 1'b0;
      end
    end else begin
      state_q        <= state_d;
      status_q       <= status_d;
      status_valid_q <= status_valid_d;
      dispense_q     <= dispense_d;
      eject_q        <= eject_d;
      card_prev_q    <= card_in;
      balance_q      <= balance_d;
      dispense_amt_q <= dispense_amt_d;
      amt_q          <= amt_d;
      op_q           <= op_d;
      pin_q          <= pin_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      pin_tab_q      <= pin_tab_d;
      bal_tab_q      <= bal_tab_d;
      tries_q        <= tries_d;
      lock_q         <= lock_d;
    end
  end

  assign state        = state_q;
  assign status       = status_q;
  assign status_valid = status_valid_q;
  assign balance      = balance_q;
  assign dispense     = dispense_q;
  assign dispense_amt = dispense_amt_q;
  assign eject        = eject_q;
endmodule
